mem_arb_rr: RTL
===============

// Module: mem_arb_rr
// PURPOSE
// - N-way round-robin arbiter between cache miss engines (L1D, L1I, prefetch, ...) and the single memory port.
// - Captures each requester's request pulse and payload into a holding register.
// - Issues one downstream transaction at a time and routes the response back one-hot to the owning requester.
// - Replaces the fixed two-way L1D/L1I arbiter in the core top level.
// PARAMETERS
// - NUM_REQ  4    number of requesters (>=2); LG_REQ = $clog2(NUM_REQ)
// - ADDR_W   64   request address width
// - DATA_W   128  cache-line data width (store data and load data)
// - TAG_W    2    memory tag width
// - OP_W     5    memory opcode width
// PORTS
// - clk                 in   1             clock
// - reset_n             in   1             synchronous reset, active low
// - req_valid           in   NUM_REQ       per-requester one-cycle request pulse
// - req_addr            in   NUM_REQ*ADDR_W packed, slice i belongs to requester i
// - req_store_data      in   NUM_REQ*DATA_W packed store data
// - req_tag             in   NUM_REQ*TAG_W  packed tags
// - req_opcode          in   NUM_REQ*OP_W   packed opcodes
// - req_pending         out  NUM_REQ       holding register i is occupied or in flight
// - rsp_valid           out  NUM_REQ       one-hot, one-cycle response strobe
// - rsp_load_data       out  DATA_W        broadcast mem_rsp_load_data
// - rsp_tag             out  TAG_W         broadcast mem_rsp_tag
// - rsp_opcode          out  OP_W          broadcast mem_rsp_opcode
// - mem_req_valid       out  1             downstream request valid
// - mem_req_ack         in   1             downstream accepts request
// - mem_req_addr        out  ADDR_W        from granted holding register
// - mem_req_store_data  out  DATA_W        from granted holding register
// - mem_req_tag         out  TAG_W         from granted holding register
// - mem_req_opcode      out  OP_W          from granted holding register
// - mem_req_src         out  LG_REQ        index of granted requester (generalises mem_req_insn)
// - mem_rsp_valid       in   1             downstream response strobe
// - mem_rsp_load_data   in   DATA_W        response data
// - mem_rsp_tag         in   TAG_W         response tag
// - mem_rsp_opcode      in   OP_W          response opcode
// - proto_err           out  1             sticky protocol-error flag
// BEHAVIOUR
// - Reset (reset_n=0 at posedge): state=IDLE, pending=0, last_gnt=NUM_REQ-1, so requester 0 wins first.
//   All outputs 0, including rsp_valid, mem_req_valid and proto_err.
// - Capture: req_valid[i]=1 with pending[i]=0 loads payload i and sets pending[i] at the next edge.
//   req_valid[i] while pending[i]=1 is dropped (first payload kept) and sets proto_err.
// - FSM IDLE: if any pending bit is set and not in flight, grant the first index found searching
//   from (last_gnt+1) mod NUM_REQ upward with wrap. Set last_gnt and go to ISSUE.
//   A pulse arriving in cycle t issues at the earliest in cycle t+2.
// - FSM ISSUE: mem_req_valid=1 with the payload stable.
//   - mem_req_ack=1 -> WAIT_RSP.
//   - mem_req_ack=1 and mem_rsp_valid=1 in the same cycle -> treat as response (below).
// - FSM WAIT_RSP: mem_req_valid=0; mem_rsp_valid=1 gives:
//   - rsp_valid[gnt]=1 for exactly that cycle (combinational from mem_rsp_valid);
//   - pending[gnt] cleared at the edge; state -> IDLE.
//   - Minimum one IDLE cycle between downstream transactions.
// - A new pulse from the granted requester in its response cycle is captured: pending stays 1 with the new payload.
// - mem_rsp_valid in IDLE, or in ISSUE without ack: ignored, sets proto_err. proto_err clears only on reset.
// - mem_req_src/addr/tag/opcode/store_data are driven from the granted slot in ISSUE and WAIT_RSP; 0 in IDLE.
// - Fairness: with all requesters continuously pending, grants cycle 0,1,..,NUM_REQ-1,0,...
// - Reset mid-transaction aborts everything: the outstanding response is not delivered, all pending bits clear.
// CONFIGURATION
// - MEM_ARB_STATS_EN defined:
//   - adds output grant_count [NUM_REQ*64], a per-requester 64-bit counter incremented on each IDLE->ISSUE grant;
//   - adds output stall_cycles [64], incremented each cycle that some pending requester is not granted;
//   - both reset to 0 and wrap modulo 2^64.
// - Undefined: neither port nor any counter logic exists; all other behaviour is identical.
// TESTING
// - Single request: req_valid=4'b0100, addr=0x1000 at cycle 0.
//   -> mem_req_valid=1 at cycle 2, src=2, addr=0x1000; ack at 3, rsp at 6 -> rsp_valid=4'b0100 at cycle 6 only.
// - Round robin: all 4 pulse together, ack and rsp each 1 cycle later.
//   -> grant order 0,1,2,3; reissue of 0 only after 3.
// - Re-request on response: requester 1 pulses again in its rsp cycle with addr 0x2000.
//   -> pending[1] stays 1; its next issue carries 0x2000.
// - Errors: duplicate pulse while pending -> payload unchanged, proto_err=1; stray mem_rsp_valid in IDLE -> no rsp_valid, proto_err=1.
// - Reset mid-transaction: reset_n=0 in WAIT_RSP then rsp arrives -> no rsp_valid; all outputs 0; next grant goes to requester 0.
// - Stats (MEM_ARB_STATS_EN): after the round-robin test, grant_count={1,1,1,1} and stall_cycles equals the bench-computed wait total.

Source files
------------

// File: rtl/mem_arb_rr.sv
// Round-robin arbiter: NUM_REQ miss engines share one memory port, one transaction in flight.
// Optional per-requester grant and stall counters are enabled with MEM_ARB_STATS_EN.

module mem_arb_rr_slot #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  input  logic          rsp_done,
  input  logic [PW-1:0] payload_in,
  output logic          pending,
  output logic [PW-1:0] payload,
  output logic          dup
);
  // A pulse in the owner's response cycle refills the slot instead of being dropped.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending <= 1'b0;
      payload <= '0;
    end else if (req_valid && (!pending || rsp_done)) begin
      pending <= 1'b1;
      payload <= payload_in;
    end else if (rsp_done) begin
      pending <= 1'b0;
    end
  end

  assign dup = req_valid && pending && !rsp_done;
endmodule

module mem_arb_rr #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 128,
  parameter int TAG_W   = 2,
  parameter int OP_W    = 5,
  parameter int LG_REQ  = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_store_data,
  input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
  input  logic [NUM_REQ*OP_W-1:0]     req_opcode,
  output logic [NUM_REQ-1:0]          req_pending,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_load_data,
  output logic [TAG_W-1:0]            rsp_tag,
  output logic [OP_W-1:0]             rsp_opcode,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ack,
  output logic [ADDR_W-1:0]           mem_req_addr,
  output logic [DATA_W-1:0]           mem_req_store_data,
  output logic [TAG_W-1:0]            mem_req_tag,
  output logic [OP_W-1:0]             mem_req_opcode,
  output logic [LG_REQ-1:0]           mem_req_src,
  input  logic                        mem_rsp_valid,
  input  logic [DATA_W-1:0]           mem_rsp_load_data,
  input  logic [TAG_W-1:0]            mem_rsp_tag,
  input  logic [OP_W-1:0]             mem_rsp_opcode,
`ifdef MEM_ARB_STATS_EN
  output logic [NUM_REQ*64-1:0]       grant_count,
  output logic [63:0]                 stall_cycles,
`endif
  output logic                        proto_err
);
  localparam int PW = ADDR_W + DATA_W + TAG_W + OP_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic [OP_W-1:0]   op;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

  state_t                state, state_nx;
  logic [LG_REQ-1:0]     last_gnt;
  req_t [NUM_REQ-1:0]    slot_in, slot_q;
  logic [NUM_REQ-1:0]    pending, dup, rsp_done, gnt_oh;
  logic                  found, rsp_fire;
  logic [LG_REQ-1:0]     pick;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign slot_in[i] = {req_addr[i*ADDR_W +: ADDR_W], req_store_data[i*DATA_W +: DATA_W],
                         req_tag[i*TAG_W +: TAG_W], req_opcode[i*OP_W +: OP_W]};
    mem_arb_rr_slot #(.PW(PW)) u_slot (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid[i]),
      .rsp_done   (rsp_done[i]),
      .payload_in (slot_in[i]),
      .pending    (pending[i]),
      .payload    (slot_q[i]),
      .dup        (dup[i])
    );
  end

  // Search upward from last_gnt+1 with wrap; the first pending index wins.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_gnt) + k) % NUM_REQ;
      if (!found && pending[idx]) begin
        found = 1'b1;
        pick  = LG_REQ'(idx);
      end
    end
  end

  always_comb begin
    gnt_oh           = '0;
    gnt_oh[last_gnt] = 1'b1;
  end

  assign rsp_fire = mem_rsp_valid &&
                    ((state == WAIT_RSP) || (state == ISSUE && mem_req_ack));
  assign rsp_done = rsp_fire ? gnt_oh : '0;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      last_gnt  <= LG_REQ'(NUM_REQ - 1);
      proto_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && found) last_gnt <= pick;
      if ((|dup) || (mem_rsp_valid && !rsp_fire)) proto_err <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (found) state_nx = ISSUE;
      ISSUE:    if (rsp_fire) state_nx = IDLE;
                else if (mem_req_ack) state_nx = WAIT_RSP;
      WAIT_RSP: if (rsp_fire) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Outputs; rsp_valid is masked during reset so an aborted response never leaks out.
  always_comb begin
    req_t cur;
    cur                = slot_q[last_gnt];
    mem_req_valid      = (state == ISSUE);
    mem_req_addr       = '0;
    mem_req_store_data = '0;
    mem_req_tag        = '0;
    mem_req_opcode     = '0;
    mem_req_src        = '0;
    if (state != IDLE) begin
      mem_req_addr       = cur.addr;
      mem_req_store_data = cur.data;
      mem_req_tag        = cur.tag;
      mem_req_opcode     = cur.op;
      mem_req_src        = last_gnt;
    end
    rsp_valid = (reset_n && rsp_fire) ? gnt_oh : '0;
  end

  assign req_pending   = pending;
  assign rsp_load_data = mem_rsp_load_data;
  assign rsp_tag       = mem_rsp_tag;
  assign rsp_opcode    = mem_rsp_opcode;

`ifdef MEM_ARB_STATS_EN
  logic [NUM_REQ-1:0][63:0] gnt_cnt;
  logic [NUM_REQ-1:0]       owner;
  logic [63:0]              stall_q;

  // The owner is the slot in flight, or the one being granted this IDLE cycle.
  always_comb begin
    owner = '0;
    if (state != IDLE) owner = gnt_oh;
    else if (found)    owner[pick] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      gnt_cnt <= '0;
      stall_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (state == IDLE && found && pick == LG_REQ'(i)) gnt_cnt[i] <= gnt_cnt[i] + 64'd1;
      if (|(pending & ~owner)) stall_q <= stall_q + 64'd1;
    end
  end

  assign grant_count  = gnt_cnt;
  assign stall_cycles = stall_q;
`endif
endmodule
